// File: rtl/mem10w_write_arbiter_if.sv
// Bus bundle for mem10w_write_arbiter: requester handshake, memory write port
// and memory read port 2. The arbiter uses the slave modport; requesters and
// the memory model use the master modport.
interface mem10w_write_arbiter_if;
    logic [3:0]   req;
    logic [15:0]  req_addr;
    logic [139:0] req_data;
    logic [3:0]   gnt;
    logic [3:0]   err;
    logic         busy;
    logic         WR;
    logic [3:0]   wr_address_word;
    logic [34:0]  wr_data_word;
    logic [3:0]   address_word_2;
    logic [34:0]  data_word_2;
    logic [7:0]   verify_fail_cnt;

    modport slave (
        input  req, req_addr, req_data, data_word_2,
        output gnt, err, busy, WR, wr_address_word, wr_data_word,
               address_word_2, verify_fail_cnt
    );

    modport master (
        output req, req_addr, req_data, data_word_2,
        input  gnt, err, busy, WR, wr_address_word, wr_data_word,
               address_word_2, verify_fail_cnt
    );
endinterface

// File: rtl/mem10w_write_arbiter.sv
// Round-robin write arbiter for a 10-word, 35-bit memory.
// Four requesters each present an address/data pair; one is chosen per
// transaction, written in a single WR cycle, and acknowledged with a gnt pulse
// (plus err on an out-of-range address or read-back mismatch).
// Optional feature: define MEM10W_WR_VERIFY_EN to add a VERIFY state that reads
// the word back through read port 2 and counts mismatches.
module mem10w_write_arbiter #(
    parameter int NREQ  = 4,
    parameter int DEPTH = 10
) (
    input logic                  CLOCK_50,
    input logic                  RESET_N,
    mem10w_write_arbiter_if.slave bus
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] WRITE  = 2'd1;
`ifdef MEM10W_WR_VERIFY_EN
    localparam logic [1:0] VERIFY = 2'd2;
`endif
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [1:0]  last_granted;
    logic [1:0]  idx;
    logic        err_flag;
    logic [3:0]  lat_addr;
    logic [34:0] lat_data;
    logic        addr_ok;

    logic [3:0]  eligible;
    logic [1:0]  cand;
    logic        sel_found;
    logic [1:0]  sel_idx;

`ifdef MEM10W_WR_VERIFY_EN
    logic        mismatch;
    logic [7:0]  fail_cnt;
`else
    logic        unused_rd;
`endif

    assign addr_ok = ({28'd0, lat_addr} < DEPTH);

    // Round-robin pick: search upward from last_granted+1 with wrap; a
    // requester whose gnt is currently pulsing is never picked again.
    always_comb begin
        eligible  = bus.req & ~bus.gnt;
        cand      = '0;
        sel_found = 1'b0;
        sel_idx   = last_granted;
        for (int i = 1; i <= NREQ; i++) begin
            cand = last_granted + 2'(i);
            if (!sel_found && eligible[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // Next-state decode for the transaction sequence.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (sel_found) state_nxt = WRITE;
`ifdef MEM10W_WR_VERIFY_EN
            WRITE:  state_nxt = addr_ok ? VERIFY : DONE;
            VERIFY: state_nxt = DONE;
`else
            WRITE:  state_nxt = DONE;
`endif
            DONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control state: FSM, round-robin pointer, granted index and error flag.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state        <= IDLE;
            last_granted <= 2'd3;
            idx          <= 2'd0;
            err_flag     <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        last_granted <= sel_idx;
                        idx          <= sel_idx;
                        err_flag     <= 1'b0;
                    end
                end
                WRITE: begin
                    if (!addr_ok) err_flag <= 1'b1;
                end
`ifdef MEM10W_WR_VERIFY_EN
                VERIFY: begin
                    if (mismatch) err_flag <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    // Capture the selected requester's address and data at selection time.
    always_ff @(posedge CLOCK_50) begin
        if (state == IDLE && sel_found) begin
            lat_addr <= bus.req_addr[4*sel_idx +: 4];
            lat_data <= bus.req_data[35*sel_idx +: 35];
        end
    end

`ifdef MEM10W_WR_VERIFY_EN
    assign mismatch = (bus.data_word_2 != lat_data);

    // Saturating count of read-back mismatches.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            fail_cnt <= 8'd0;
        end else if (state == VERIFY && mismatch && fail_cnt != 8'hFF) begin
            fail_cnt <= fail_cnt + 8'd1;
        end
    end

    assign bus.verify_fail_cnt = fail_cnt;
`else
    assign unused_rd           = ^bus.data_word_2;
    assign bus.verify_fail_cnt = 8'd0;
`endif

    // Outputs decoded from state so they are zero outside their own state and
    // drop immediately when reset is asserted.
    always_comb begin
        bus.WR              = 1'b0;
        bus.wr_address_word = '0;
        bus.wr_data_word    = '0;
        bus.address_word_2  = '0;
        bus.gnt             = '0;
        bus.err             = '0;
        bus.busy            = (state != IDLE);
        case (state)
            WRITE: begin
                if (addr_ok) begin
                    bus.WR              = 1'b1;
                    bus.wr_address_word = lat_addr;
                    bus.wr_data_word    = lat_data;
                end
            end
`ifdef MEM10W_WR_VERIFY_EN
            VERIFY: bus.address_word_2 = lat_addr;
`endif
            DONE: begin
                bus.gnt[idx] = 1'b1;
                bus.err[idx] = err_flag;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem10w_write_arbiter.sv
// Scoreboard bench for mem10w_write_arbiter: stimulus pushes expected writes
// and grants into queues, a negedge monitor pops and compares them.
module tb_mem10w_write_arbiter;

`ifdef MEM10W_WR_VERIFY_EN
    localparam int V = 1;
`else
    localparam int V = 0;
`endif
    localparam int P = 3 + V;

    typedef struct {
        logic [3:0]  addr;
        logic [34:0] data;
        int          cyc;
    } wr_exp_t;

    typedef struct {
        logic [3:0] gnt;
        logic [3:0] err;
        int         cyc;
    } gnt_exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic corrupt = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    wr_exp_t  exp_wr[$];
    gnt_exp_t exp_gnt[$];
    wr_exp_t  mw;
    gnt_exp_t mg;
    logic [34:0] mem [0:15];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem10w_write_arbiter_if bus();

    mem10w_write_arbiter #(.NREQ(4), .DEPTH(10)) dut (
        .CLOCK_50(clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    // memory model: synchronous write, combinational read port 2
    initial for (int i = 0; i < 16; i++) mem[i] = '0;
    always @(posedge clk) if (bus.WR) mem[bus.wr_address_word] <= bus.wr_data_word;
    assign bus.data_word_2 = mem[bus.address_word_2] ^ {34'd0, corrupt};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // monitor
    always @(negedge clk) begin
        if (bus.WR) begin
            if (exp_wr.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_wr addr=%0d data=0x%0h cyc=%0d",
                         bus.wr_address_word, bus.wr_data_word, cyc);
            end else begin
                mw = exp_wr.pop_front();
                chk("wr_addr", 64'(bus.wr_address_word), 64'(mw.addr));
                chk("wr_data", 64'(bus.wr_data_word), 64'(mw.data));
                chk("wr_cycle", 64'(cyc), 64'(mw.cyc));
            end
        end else begin
            chk("wr_idle_zero", 64'({bus.wr_address_word, bus.wr_data_word}), 64'd0);
        end
        if (bus.gnt != 4'd0) begin
            if (exp_gnt.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_gnt gnt=%b err=%b cyc=%0d", bus.gnt, bus.err, cyc);
            end else begin
                mg = exp_gnt.pop_front();
                chk("gnt", 64'(bus.gnt), 64'(mg.gnt));
                chk("err", 64'(bus.err), 64'(mg.err));
                chk("gnt_cycle", 64'(cyc), 64'(mg.cyc));
            end
        end else begin
            chk("err_without_gnt", 64'(bus.err), 64'd0);
        end
`ifndef MEM10W_WR_VERIFY_EN
        chk("rd_port_tied", 64'({bus.address_word_2, bus.verify_fail_cnt}), 64'd0);
`endif
    end

    task automatic set_port(input int r, input logic [3:0] a, input logic [34:0] d);
        bus.req_addr[4*r +: 4]   = a;
        bus.req_data[35*r +: 35] = d;
    endtask

    task automatic expect_txn(input int r, input logic [3:0] a, input logic [34:0] d,
                              input logic e, input int wr_cyc);
        wr_exp_t  w;
        gnt_exp_t g;
        logic     ok;
        ok = (a < 4'd10);
        if (ok) begin
            w.addr = a; w.data = d; w.cyc = wr_cyc;
            exp_wr.push_back(w);
        end
        g.gnt = 4'(1 << r);
        g.err = e ? g.gnt : 4'd0;
        g.cyc = wr_cyc + 1 + ((ok && V == 1) ? 1 : 0);
        exp_gnt.push_back(g);
    endtask

    // requesters drop req on their gnt; returns once everything is idle
    task automatic wait_done(input int budget);
        int k;
        k = 0;
        forever begin
            @(negedge clk);
            bus.req = bus.req & ~bus.gnt;
            if (bus.req == 4'd0 && !bus.busy && bus.gnt == 4'd0) break;
            k++;
            if (k >= budget) begin
                checks++; failures++;
                $display("FAIL txn_timeout req=%b budget=%0d", bus.req, budget);
                bus.req = 4'd0;
                break;
            end
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_gnt", 64'(bus.gnt), 64'd0);
        chk("rst_err", 64'(bus.err), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_wr", 64'(bus.WR), 64'd0);
        chk("rst_wr_bus", 64'({bus.wr_address_word, bus.wr_data_word}), 64'd0);
        chk("rst_rd_addr", 64'(bus.address_word_2), 64'd0);
        chk("rst_vfc", 64'(bus.verify_fail_cnt), 64'd0);
    endtask

    task automatic do_reset();
        bus.req = 4'd0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.req      = 4'd0;
        bus.req_addr = '0;
        bus.req_data = '0;

        do_reset();
        chk("idle_busy", 64'(bus.busy), 64'd0);

        // single request, addr 3
        set_port(0, 4'd3, 35'h1_2345_6789);
        n = cyc; bus.req = 4'b0001;
        expect_txn(0, 4'd3, 35'h1_2345_6789, 1'b0, n + 1);
        wait_done(20);

        // all four after reset: order 0,1,2,3
        do_reset();
        for (int i = 0; i < 4; i++) set_port(i, 4'(i), 35'h5_0000_0000 | 35'(i * 17));
        n = cyc; bus.req = 4'b1111;
        for (int i = 0; i < 4; i++)
            expect_txn(i, 4'(i), 35'h5_0000_0000 | 35'(i * 17), 1'b0, n + 1 + i * P);
        wait_done(40);

        // out of range addr 12 on requester 2
        set_port(2, 4'd12, 35'h7_FFFF_FFFF);
        n = cyc; bus.req = 4'b0100;
        expect_txn(2, 4'd12, 35'h7_FFFF_FFFF, 1'b1, n + 1);
        wait_done(20);

        // first invalid address (10) on requester 1
        set_port(1, 4'd10, 35'h0_0000_00AA);
        n = cyc; bus.req = 4'b0010;
        expect_txn(1, 4'd10, 35'h0_0000_00AA, 1'b1, n + 1);
        wait_done(20);

        // last_granted=1: order 3,0,1; addr 9 is the last valid word
        set_port(3, 4'd9, 35'h3_1111_2222);
        set_port(0, 4'd7, 35'h2_3333_4444);
        set_port(1, 4'd8, 35'h1_5555_6666);
        n = cyc; bus.req = 4'b1011;
        expect_txn(3, 4'd9, 35'h3_1111_2222, 1'b0, n + 1);
        expect_txn(0, 4'd7, 35'h2_3333_4444, 1'b0, n + 1 + P);
        expect_txn(1, 4'd8, 35'h1_5555_6666, 1'b0, n + 1 + 2 * P);
        wait_done(40);

        // reset during WRITE aborts: WR drops at once, no gnt
        set_port(0, 4'd4, 35'h2_AAAA_5555);
        n = cyc; bus.req = 4'b0001;
        expect_txn(0, 4'd4, 35'h2_AAAA_5555, 1'b0, n + 1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        bus.req = 4'd0;
        #1;
        chk("abort_wr", 64'(bus.WR), 64'd0);
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_gnt", 64'(bus.gnt), 64'd0);
        exp_gnt.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        // pointer back to 3: requester 0 ahead of 1
        set_port(0, 4'd5, 35'h0_1234_0000);
        set_port(1, 4'd6, 35'h0_0000_4321);
        n = cyc; bus.req = 4'b0011;
        expect_txn(0, 4'd5, 35'h0_1234_0000, 1'b0, n + 1);
        expect_txn(1, 4'd6, 35'h0_0000_4321, 1'b0, n + 1 + P);
        wait_done(30);

`ifdef MEM10W_WR_VERIFY_EN
        // read-back mismatch
        corrupt = 1'b1;
        set_port(0, 4'd2, 35'h4_0F0F_0F0F);
        n = cyc; bus.req = 4'b0001;
        expect_txn(0, 4'd2, 35'h4_0F0F_0F0F, 1'b1, n + 1);
        wait_done(20);
        chk("vfc_one", 64'(bus.verify_fail_cnt), 64'd1);
        for (int i = 1; i < 300; i++) begin
            set_port(0, 4'(i % 10), 35'(i));
            n = cyc; bus.req = 4'b0001;
            expect_txn(0, 4'(i % 10), 35'(i), 1'b1, n + 1);
            wait_done(20);
        end
        chk("vfc_saturated", 64'(bus.verify_fail_cnt), 64'd255);
        corrupt = 1'b0;
        set_port(0, 4'd1, 35'h6_0000_0001);
        n = cyc; bus.req = 4'b0001;
        expect_txn(0, 4'd1, 35'h6_0000_0001, 1'b0, n + 1);
        wait_done(20);
        chk("vfc_hold", 64'(bus.verify_fail_cnt), 64'd255);
`else
        chk("vfc_tied", 64'(bus.verify_fail_cnt), 64'd0);
`endif

        repeat (2) @(negedge clk);
        chk("sb_wr_drained", 64'(exp_wr.size()), 64'd0);
        chk("sb_gnt_drained", 64'(exp_gnt.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem10w_write_arbiter.md
MEM10W_WRITE_ARBITER -- requirements
Module: mem10w_write_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of write requesters (fixed at 4 for this release).
REQ-002 The block SHALL have parameter DEPTH, default 10, giving the number of valid memory words.
REQ-003 The block SHALL have port CLOCK_50, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 The block SHALL have port RESET_N, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port req, input, 4 bits: per-requester write request, held high until the matching gnt bit pulses.
REQ-006 The block SHALL have port req_addr, input, 16 bits: 4-bit word address per requester; requester i uses bits [4i+3:4i].
REQ-007 The block SHALL have port req_data, input, 140 bits: 35-bit data per requester; requester i uses bits [35i+34:35i].
REQ-008 The block SHALL have port gnt, output, 4 bits: one-cycle completion pulse, one-hot.
REQ-009 The block SHALL have port err, output, 4 bits: one-cycle pulse coincident with gnt on an out-of-range address or verify mismatch.
REQ-010 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-011 The block SHALL have port WR, output, 1 bit: memory write enable.
REQ-012 The block SHALL have port wr_address_word, output, 4 bits: memory write address.
REQ-013 The block SHALL have port wr_data_word, output, 35 bits: memory write data.
REQ-014 The block SHALL have port address_word_2, output, 4 bits: memory read port 2 address.
REQ-015 The block SHALL have port data_word_2, input, 35 bits: memory read port 2 data, combinational from address_word_2.
REQ-016 The block SHALL have port verify_fail_cnt, output, 8 bits: saturating count of verify mismatches.

Function
REQ-017 The FSM SHALL have states IDLE, WRITE, VERIFY (VERIFY present only per REQ-030), and DONE.
REQ-018 IDLE, some eligible req high: select one requester round-robin, latch its index, address, and data, then go to WRITE.
REQ-019 Round-robin priority SHALL start at (last_granted+1) mod 4 and search upward with wrap.
REQ-020 The last_granted pointer SHALL update only on selection.
REQ-021 In WRITE, WR SHALL be 1 for exactly one cycle with the latched address and data, only if the latched address is < DEPTH; otherwise WR SHALL be 0 and an error flag SHALL be set.
REQ-022 WRITE SHALL go to VERIFY if compiled in and the address is valid, else to DONE.
REQ-023 DONE SHALL pulse gnt[idx] and, if the error flag is set, err[idx] for one cycle, then return to IDLE.
REQ-024 Latency without verify SHALL be: req sampled at edge k, WR high in cycle k+1, gnt high in cycle k+2; the verify path adds one cycle.
REQ-025 In the cycle gnt[i] is high, req[i] SHALL be masked from selection, so a held req cannot double-issue.
REQ-026 WR, wr_address_word, and wr_data_word SHALL be 0 outside WRITE, and address_word_2 SHALL be 0 outside VERIFY.
REQ-027 verify_fail_cnt SHALL increment by 1 per mismatch, saturate at 255, and not wrap.
REQ-028 Simultaneous requests SHALL be served one per transaction, with every active requester served within 4 transactions.

Reset
REQ-029 While RESET_N is 0, asynchronously: state=IDLE, last_granted=3 (requester 0 first), gnt=0, err=0, busy=0, WR=0, all address/data outputs 0, verify_fail_cnt=0; a reset mid-transaction SHALL abort with no gnt and no WR.

Configuration
REQ-030 With macro MEM10W_WR_VERIFY_EN defined, VERIFY SHALL drive address_word_2 = latched address, compare data_word_2 to latched data in the same cycle, and on mismatch set the error flag and increment verify_fail_cnt.
REQ-031 Without MEM10W_WR_VERIFY_EN, VERIFY SHALL not exist, address_word_2 SHALL be tied to 0, and verify_fail_cnt SHALL be tied to 0.

Verification
REQ-032 Single request: req=0001, addr0=3, data0=0x1_2345_6789 -> WR=1 with addr 3/data 0x123456789 in cycle k+1; gnt=0001, err=0000 in cycle k+2 (k+3 with verify).
REQ-033 All four requesting after reset with addresses 0..3 -> gnt order 0,1,2,3, one transaction each, no repeats.
REQ-034 Out of range: req=0100, addr2=12 -> WR stays 0; gnt=0100 and err=0100 together.
REQ-035 Verify, with MEM10W_WR_VERIFY_EN: model returns data_word_2 = written^1 -> err pulses and verify_fail_cnt=1; after 300 forced mismatches the count reads 255.
REQ-036 Reset mid-op: RESET_N low during the WRITE cycle -> WR falls immediately, no gnt; after release, req0 is served first.
